// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and op-class helper for alu_muldiv.
package alu_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MFHI  = 4'b1101;
  localparam logic [3:0] ALU_MFLO  = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned magnitude datapath: shift-add multiplier and restoring divider,
// one bit per step_i, with {hi_o,lo_o} holding product or {remainder,quotient}.
module alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         step_i,
  input  logic         is_div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic         last_o
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, m_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    add_sum, trial;

  // lo holds the multiplier (mul) or the dividend shifting into the remainder (div)
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    trial   = {hi_q, lo_q[W-1]} - {1'b0, m_q};
    if (div_q) begin
      if (!trial[W]) begin
        hi_d = trial[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[W-2:0], lo_q[W-1]};
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      hi_d = add_sum[W:1];
      lo_d = {add_sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= is_div_i ? a_i : b_i;
      m_q   <= is_div_i ? b_i : a_i;
      div_q <= is_div_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/alu_muldiv.sv
// Registered MIPS-style ALU with iterative mul/div, HI/LO and valid/ready handshake.
// Define ALU_OVF_EN to build the signed ADD/SUB overflow flag.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] ALUop,
  input  logic [W-1:0]   opA,
  input  logic [W-1:0]   opB,
  output logic           out_valid,
  output logic [W-1:0]   result,
  output logic           zero,
  output logic           div0,
  output logic           overflow
);

  state_t       state_q;
  logic [W-1:0] hi_q, lo_q, result_q, a_q, res_d, sum, diff;
  logic [W-1:0] it_hi, it_lo, fix_hi_d, fix_lo_d, a_mag, b_mag;
  logic         zero_q, div0_q, valid_q, div_q, neg_lo_q, neg_hi_q, bzero_q;
  logic         accept, signed_op, div_op, a_neg, b_neg, it_last;

  assign accept    = in_valid && in_ready;
  assign signed_op = (ALUop == ALU_MULT) || (ALUop == ALU_DIV);
  assign div_op    = (ALUop == ALU_DIV) || (ALUop == ALU_DIVU);
  assign a_neg     = signed_op && opA[W-1];
  assign b_neg     = signed_op && opB[W-1];
  assign a_mag     = a_neg ? -opA : opA;
  assign b_mag     = b_neg ? -opB : opB;
  assign sum       = opA + opB;
  assign diff      = opA - opB;

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && is_muldiv(ALUop)),
    .step_i   (state_q == CALC),
    .is_div_i (div_op),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .hi_o     (it_hi),
    .lo_o     (it_lo),
    .last_o   (it_last)
  );

  always_comb begin
    res_d = '0;
    case (ALUop)
      ALU_AND:  res_d = opA & opB;
      ALU_OR:   res_d = opA | opB;
      ALU_XOR:  res_d = opA ^ opB;
      ALU_NOR:  res_d = ~(opA | opB);
      ALU_ADD:  res_d = sum;
      ALU_SUB:  res_d = diff;
      ALU_SLT:  res_d = {{(W-1){1'b0}}, ($signed(opA) < $signed(opB))};
      ALU_SLTU: res_d = {{(W-1){1'b0}}, (opA < opB)};
      ALU_MFHI: res_d = hi_q;
      ALU_MFLO: res_d = lo_q;
      default:  res_d = '0;
    endcase
  end

  // Divide-by-zero bypasses the datapath result entirely; sign fixes apply otherwise
  always_comb begin
    fix_hi_d = it_hi;
    fix_lo_d = it_lo;
    if (!div_q) begin
      if (neg_lo_q) {fix_hi_d, fix_lo_d} = -{it_hi, it_lo};
    end else if (bzero_q) begin
      fix_hi_d = a_q;
      fix_lo_d = '1;
    end else begin
      if (neg_lo_q) fix_lo_d = -it_lo;
      if (neg_hi_q) fix_hi_d = -it_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      div0_q   <= 1'b0;
      valid_q  <= 1'b0;
      a_q      <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (is_muldiv(ALUop)) begin
            state_q  <= CALC;
            a_q      <= opA;
            div_q    <= div_op;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            bzero_q  <= (opB == '0);
          end else begin
            result_q <= res_d;
            zero_q   <= (res_d == '0);
            div0_q   <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        CALC: if (it_last) state_q <= FIX;
        FIX: begin
          hi_q     <= fix_hi_d;
          lo_q     <= fix_lo_d;
          result_q <= fix_lo_d;
          zero_q   <= (fix_lo_d == '0);
          div0_q   <= div_q && bzero_q;
          valid_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    if (ALUop == ALU_ADD)
      ovf_d = (opA[W-1] == opB[W-1]) && (sum[W-1] != opA[W-1]);
    else if (ALUop == ALU_SUB)
      ovf_d = (opA[W-1] != opB[W-1]) && (diff[W-1] != opA[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (accept && !is_muldiv(ALUop))
      ovf_q <= ovf_d;
    else if (state_q == FIX)
      ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule
